uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter among four byte sources, e.g. the RX echo path plus status or debug generators. Each source raises a one-cycle data-valid strobe, like `uart_rx`'s `o_RX_DV`. The arbiter latches the byte in a per-source holding register and issues bytes to `uart_tx` one frame at a time. It waits for `o_TX_Done` before issuing the next byte, then inserts an optional idle gap.

## Interface
- `GAP_CLKS`, default 0: idle clocks inserted after each `i_TX_Done` before the next grant; 0 means no gap.
- `TIMEOUT_CLKS`, default 4096: watchdog limit in WAIT_DONE; used only with `UART_TX_ARB_TIMEOUT_EN`.
- `i_Clk`  in  1  system clock, all logic rising-edge.
- `i_Rst`  in  1  reset, asynchronous, active-high.
- `i_Req_DV`  in  4  per-source one-cycle byte-valid strobe.
- `i_Req_Byte`  in  32  source k byte on [8k+7:8k]; sampled when `i_Req_DV[k]`=1.
- `o_Req_Pending`  out  4  holding register k full.
- `o_Req_Drop`  out  4  one-cycle pulse when source k's strobe is discarded.
- `o_TX_DV`  out  1  one-cycle start strobe to `uart_tx` `i_TX_DV`.
- `o_TX_Byte`  out  8  byte to `uart_tx` `i_TX_Byte`; held stable from ISSUE until the next ISSUE.
- `i_TX_Done`  in  1  one-cycle frame-complete pulse from `uart_tx` `o_TX_Done`.
- `o_Grant_Id`  out  2  index of the source currently owning the transmitter.
- `o_Busy`  out  1  1 whenever state is not IDLE.
- `o_Timeout`  out  1  one-cycle watchdog-expiry pulse.

## Operation
- Reset value of all outputs, state, pending bits and holding registers is 0. State resets to IDLE and the round-robin pointer to 0.
- Capture: on `i_Req_DV[k]` with `o_Req_Pending[k]`=0, load the byte into holding register k and set pending k.
- Drop: on `i_Req_DV[k]` with pending k=1, and k not granted that same edge, discard the new byte, keep the old one and pulse `o_Req_Drop[k]`.
- Simultaneous grant and strobe on the same source: the grant consumes the old byte and the new byte is captured, so pending stays 1 with no drop.
- States:
  - IDLE: if any pending, select the first pending index searching from `ptr`, ptr+1, ... modulo 4. Load `o_TX_Byte` and `o_Grant_Id`, clear that pending bit, set `ptr` = winner+1 mod 4, and go to ISSUE.
  - ISSUE (1 cycle): `o_TX_DV`=1, then go to WAIT_DONE.
  - WAIT_DONE: on `i_TX_Done`, go to GAP if `GAP_CLKS`>0, else to IDLE.
  - GAP: count `GAP_CLKS` cycles, then go to IDLE.
- Fairness: with all four sources continuously pending, grants rotate 0,1,2,3,0,...
- `i_TX_Done` outside WAIT_DONE is ignored.
- Reset mid-frame aborts arbitration only; the downstream `uart_tx` is not reset by this block.

## Timing
- Strobe at cycle 0: pending is visible at cycle 1. If IDLE, `o_TX_DV` is high at cycle 2, so strobe-to-start latency is 2 clocks.
- `i_TX_Done` at cycle D with `GAP_CLKS`=0: IDLE at D+1, next `o_TX_DV` at D+2.
- `i_TX_Done` at cycle D with `GAP_CLKS`=G: IDLE at D+1+G, next `o_TX_DV` at D+2+G.
- `o_TX_DV` is never high in two consecutive cycles.
- `o_Req_Drop[k]` pulses in the cycle after the discarded strobe.
- `o_Busy` rises with ISSUE and falls on entry to IDLE.
- Gap counter width is clog2(`GAP_CLKS`+1). Watchdog counter width is clog2(`TIMEOUT_CLKS`+1).

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - a counter runs in WAIT_DONE and clears on entry;
  - if it reaches `TIMEOUT_CLKS` without `i_TX_Done`, `o_Timeout` pulses for 1 cycle and the state goes to GAP, or to IDLE when `GAP_CLKS`=0;
  - the granted byte is lost and is not re-queued.
- Not defined:
  - WAIT_DONE waits indefinitely;
  - `o_Timeout` is tied to 0;
  - no watchdog counter logic exists.

## Test plan
- Single byte: strobe source 2 with 8'hA5 at cycle 0 → `o_TX_DV` at cycle 2, `o_TX_Byte`=A5, `o_Grant_Id`=2. Model `i_TX_Done` 2170 clocks later → `o_Busy` falls next cycle.
- Fairness: strobe all four sources in one cycle with 11,22,33,44 → issue order 11,22,33,44. Re-strobe all → next order continues from `ptr`, giving 11,22,33,44 again after wrap.
- Drop: strobe source 1 with 0x01 then 0x02 while the transmitter is busy with source 0 → `o_Req_Drop[1]` pulses once and 0x01 is later transmitted.
- Strobe on grant: re-strobe source 3 with 0x77 in the same cycle its old byte 0x66 is granted → 0x66 sent, then 0x77, no drop.
- Gap: `GAP_CLKS`=5 with two pending bytes → second `o_TX_DV` exactly 7 clocks after the first `i_TX_Done`.
- Reset/timeout:
  - assert `i_Rst` in WAIT_DONE → all outputs 0 immediately;
  - with `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CLKS`=16, withhold `i_TX_Done` → `o_Timeout` pulses 16 clocks after entering WAIT_DONE, then the next pending byte is issued.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among four one-byte sources.
// Optional watchdog in WAIT_DONE is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [3:0]  i_Req_DV,
  input  logic [31:0] i_Req_Byte,
  output logic [3:0]  o_Req_Pending,
  output logic [3:0]  o_Req_Drop,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Done,
  output logic [1:0]  o_Grant_Id,
  output logic        o_Busy,
  output logic        o_Timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam state_t AFTER_FRAME = (GAP_CLKS > 0) ? GAP : IDLE;

  state_t           state, state_d;
  logic [7:0]       hold [4];
  logic [1:0]       ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             any_pending;
  logic [1:0]       winner;
  logic             grant;
  logic             timeout_fire;

  // First pending source at or after ptr, wrapping modulo 4.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    idx         = ptr;
    winner      = ptr;
    any_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!any_pending && o_Req_Pending[idx]) begin
        any_pending = 1'b1;
        winner      = idx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic [TO_W-1:0] wd_cnt;

  // Zero on every entry to WAIT_DONE because it is held clear outside it.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wd_cnt    <= '0;
      o_Timeout <= 1'b0;
    end else begin
      wd_cnt    <= (state == WAIT_DONE) ? wd_cnt + TO_W'(1) : '0;
      o_Timeout <= timeout_fire;
    end
  end
`else
  // No watchdog in this build: the output is permanently low.
  assign o_Timeout = 1'b0 && (TIMEOUT_CLKS > 0);
`endif

  always_comb begin
    state_d      = state;
    grant        = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (any_pending) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = AFTER_FRAME;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wd_cnt == TO_LAST) begin
          timeout_fire = 1'b1;
          state_d      = AFTER_FRAME;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  // A strobe landing on the source being granted refills its slot instead of dropping.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      // NOTE: the holding registers are reset too, so o_TX_Byte can never carry X.
      for (int k = 0; k < 4; k++) hold[k] <= 8'h00;
      o_Req_Pending <= '0;
      o_Req_Drop    <= '0;
      o_TX_Byte     <= 8'h00;
      o_Grant_Id    <= 2'd0;
      ptr           <= 2'd0;
    end else begin
      o_Req_Drop <= '0;
      for (int k = 0; k < 4; k++) begin
        if (i_Req_DV[k]) begin
          if (!o_Req_Pending[k] || (grant && winner == 2'(k))) begin
            hold[k]          <= i_Req_Byte[8*k +: 8];
            o_Req_Pending[k] <= 1'b1;
          end else begin
            o_Req_Drop[k] <= 1'b1;
          end
        end else if (grant && winner == 2'(k)) begin
          o_Req_Pending[k] <= 1'b0;
        end
      end
      if (grant) begin
        o_TX_Byte  <= hold[winner];
        o_Grant_Id <= winner;
        ptr        <= winner + 2'd1;
      end
    end
  end

  assign o_TX_DV = (state == ISSUE);
  assign o_Busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; three instances share stimulus
// (GAP 0, GAP 5, and GAP 0 with a 16-clock watchdog limit).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_dv;
  logic [31:0] req_byte;
  logic        tx_done;

  logic [3:0] pend0, drop0, pend_g, drop_g, pend_t, drop_t;
  logic       dv0, busy0, to0, dv_g, busy_g, to_g, dv_t, busy_t, to_t;
  logic [7:0] byte0, byte_g, byte_t;
  logic [1:0] gid0, gid_g, gid_t;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GAP_CLKS(0)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
    .o_Req_Pending(pend0), .o_Req_Drop(drop0), .o_TX_DV(dv0), .o_TX_Byte(byte0),
    .i_TX_Done(tx_done), .o_Grant_Id(gid0), .o_Busy(busy0), .o_Timeout(to0)
  );

  uart_tx_arbiter #(.GAP_CLKS(5)) dut_g (
    .i_Clk(clk), .i_Rst(rst), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
    .o_Req_Pending(pend_g), .o_Req_Drop(drop_g), .o_TX_DV(dv_g), .o_TX_Byte(byte_g),
    .i_TX_Done(tx_done), .o_Grant_Id(gid_g), .o_Busy(busy_g), .o_Timeout(to_g)
  );

  uart_tx_arbiter #(.GAP_CLKS(0), .TIMEOUT_CLKS(16)) dut_t (
    .i_Clk(clk), .i_Rst(rst), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
    .o_Req_Pending(pend_t), .o_Req_Drop(drop_t), .o_TX_DV(dv_t), .o_TX_Byte(byte_t),
    .i_TX_Done(tx_done), .o_Grant_Id(gid_t), .o_Busy(busy_t), .o_Timeout(to_t)
  );

  wire [20:0] out0  = {pend0, drop0, dv0, byte0, gid0, busy0, to0};
  wire [20:0] out_g = {pend_g, drop_g, dv_g, byte_g, gid_g, busy_g, to_g};
  wire [20:0] out_t = {pend_t, drop_t, dv_t, byte_t, gid_t, busy_t, to_t};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_dv = '0; req_byte = '0; tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [3:0] m, input logic [31:0] b);
    req_dv = m; req_byte = b;
    tick();
    req_dv = '0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Cycles until dut raises o_TX_DV, or -1 if it never does within the budget.
  task automatic wait_tx_start(output int n);
    n = 0;
    while (!dv0 && n < 64) begin
      tick();
      n++;
    end
    if (!dv0) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_dv = '0; req_byte = '0; tx_done = 1'b0;
    tick();
    checks++;
    if (out0 !== 21'd0) begin errors++; $display("FAIL reset_dut: got %h expected 0", out0); end
    checks++;
    if (out_g !== 21'd0) begin errors++; $display("FAIL reset_dut_g: got %h expected 0", out_g); end
    checks++;
    if (out_t !== 21'd0) begin errors++; $display("FAIL reset_dut_t: got %h expected 0", out_t); end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (out0 !== 21'd0) begin errors++; $display("FAIL idle_after_reset: got %h expected 0", out0); end
  endtask

  task automatic test_single_byte();
    bit stayed;
    strobe(4'b0100, 32'h00A5_0000);
    checks++;
    if ({pend0, dv0} !== {4'b0100, 1'b0})
      begin errors++; $display("FAIL single_cycle1: pend=%b dv=%b expected 0100/0", pend0, dv0); end
    tick();
    checks++;
    if ({dv0, byte0, gid0, busy0, pend0} !== {1'b1, 8'hA5, 2'd2, 1'b1, 4'b0000})
      begin errors++; $display("FAIL single_issue: dv=%b byte=%h id=%0d busy=%b pend=%b expected 1/a5/2/1/0000",
                               dv0, byte0, gid0, busy0, pend0); end
    stayed = 1'b1;
    for (int i = 0; i < 2170; i++) begin
      tick();
      if (dv0 || !busy0) stayed = 1'b0;
    end
    checks++;
    if (stayed !== 1'b1) begin errors++; $display("FAIL single_wait: busy/dv changed before done, got 0 expected 1"); end
    pulse_done();
    checks++;
    if ({busy0, dv0, byte0, gid0} !== {1'b0, 1'b0, 8'hA5, 2'd2})
      begin errors++; $display("FAIL single_done: busy=%b dv=%b byte=%h id=%0d expected 0/0/a5/2",
                               busy0, dv0, byte0, gid0); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_byte [4];
    int n;
    exp_byte[0] = 8'h11; exp_byte[1] = 8'h22; exp_byte[2] = 8'h33; exp_byte[3] = 8'h44;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      strobe(4'b1111, 32'h4433_2211);
      for (int i = 0; i < 4; i++) begin
        wait_tx_start(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL fair_latency r%0d i%0d: got %0d expected 1", r, i, n); end
        checks++;
        if ({byte0, gid0} !== {exp_byte[i], 2'(i)})
          begin errors++; $display("FAIL fair_order r%0d i%0d: byte=%h id=%0d expected %h/%0d",
                                   r, i, byte0, gid0, exp_byte[i], i); end
        tick();
        pulse_done();
      end
    end
  endtask

  task automatic test_drop();
    int n;
    strobe(4'b0001, 32'h0000_0050);
    wait_tx_start(n);
    tick();
    strobe(4'b0010, 32'h0000_0100);
    checks++;
    if ({pend0, drop0} !== {4'b0010, 4'b0000})
      begin errors++; $display("FAIL drop_capture: pend=%b drop=%b expected 0010/0000", pend0, drop0); end
    strobe(4'b0010, 32'h0000_0200);
    checks++;
    if (drop0 !== 4'b0010) begin errors++; $display("FAIL drop_pulse: got %b expected 0010", drop0); end
    tick();
    checks++;
    if ({pend0, drop0} !== {4'b0010, 4'b0000})
      begin errors++; $display("FAIL drop_once: pend=%b drop=%b expected 0010/0000", pend0, drop0); end
    pulse_done();
    wait_tx_start(n);
    checks++;
    if ({n == 1, byte0, gid0, pend0} !== {1'b1, 8'h01, 2'd1, 4'b0000})
      begin errors++; $display("FAIL drop_kept_old: n=%0d byte=%h id=%0d pend=%b expected 1/01/1/0000",
                               n, byte0, gid0, pend0); end
    tick();
    pulse_done();
  endtask

  task automatic test_strobe_on_grant();
    int n;
    req_dv = 4'b1000; req_byte = 32'h6600_0000;
    tick();
    req_byte = 32'h7700_0000;
    tick();
    req_dv = '0;
    checks++;
    if ({dv0, byte0, gid0, pend0, drop0} !== {1'b1, 8'h66, 2'd3, 4'b1000, 4'b0000})
      begin errors++; $display("FAIL grant_strobe_issue: dv=%b byte=%h id=%0d pend=%b drop=%b expected 1/66/3/1000/0000",
                               dv0, byte0, gid0, pend0, drop0); end
    tick();
    checks++;
    if (drop0 !== 4'b0000) begin errors++; $display("FAIL grant_strobe_nodrop: got %b expected 0000", drop0); end
    pulse_done();
    wait_tx_start(n);
    checks++;
    if ({n == 1, byte0, gid0, pend0} !== {1'b1, 8'h77, 2'd3, 4'b0000})
      begin errors++; $display("FAIL grant_strobe_new: n=%0d byte=%h id=%0d pend=%b expected 1/77/3/0000",
                               n, byte0, gid0, pend0); end
    tick();
    pulse_done();
  endtask

  task automatic test_done_ignored();
    pulse_done();
    checks++;
    if ({busy0, dv0} !== 2'b00) begin errors++; $display("FAIL done_idle: busy/dv=%b expected 00", {busy0, dv0}); end
    strobe(4'b0001, 32'h0000_000F);
    tick();
    checks++;
    if (dv0 !== 1'b1) begin errors++; $display("FAIL done_issue: dv got %b expected 1", dv0); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy0, dv0} !== 2'b10) begin errors++; $display("FAIL done_in_issue: busy/dv=%b expected 10", {busy0, dv0}); end
    pulse_done();
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL done_in_wait: busy got %b expected 0", busy0); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    apply_reset();
    strobe(4'b0110, 32'h005A_3C00);
    wait_tx_start(n);
    tick();
    checks++;
    if ({byte0, gid0, pend0, busy0} !== {8'h3C, 2'd1, 4'b0100, 1'b1})
      begin errors++; $display("FAIL midreset_pre: byte=%h id=%0d pend=%b busy=%b expected 3c/1/0100/1",
                               byte0, gid0, pend0, busy0); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out0 !== 21'd0) begin errors++; $display("FAIL midreset_async: got %h expected 0", out0); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (out0 !== 21'd0) begin errors++; $display("FAIL midreset_after: got %h expected 0", out0); end
  endtask

  task automatic test_gap();
    apply_reset();
    strobe(4'b0011, 32'h0000_B1A0);
    tick();
    checks++;
    if ({dv_g, byte_g, gid_g} !== {1'b1, 8'hA0, 2'd0})
      begin errors++; $display("FAIL gap_first: dv=%b byte=%h id=%0d expected 1/a0/0", dv_g, byte_g, gid_g); end
    tick();
    pulse_done();
    checks++;
    if ({busy_g, dv_g} !== 2'b10) begin errors++; $display("FAIL gap_d1: busy/dv=%b expected 10", {busy_g, dv_g}); end
    repeat (4) tick();
    checks++;
    if ({busy_g, dv_g} !== 2'b10) begin errors++; $display("FAIL gap_d5: busy/dv=%b expected 10", {busy_g, dv_g}); end
    tick();
    checks++;
    if ({busy_g, dv_g} !== 2'b00) begin errors++; $display("FAIL gap_d6: busy/dv=%b expected 00", {busy_g, dv_g}); end
    tick();
    checks++;
    if ({dv_g, byte_g, gid_g} !== {1'b1, 8'hB1, 2'd1})
      begin errors++; $display("FAIL gap_d7: dv=%b byte=%h id=%0d expected 1/b1/1", dv_g, byte_g, gid_g); end
    tick();
    pulse_done();
  endtask

  task automatic test_timeout();
    apply_reset();
    strobe(4'b0011, 32'h0000_E2E1);
    tick();
    checks++;
    if ({dv_t, byte_t, gid_t} !== {1'b1, 8'hE1, 2'd0})
      begin errors++; $display("FAIL wd_issue: dv=%b byte=%h id=%0d expected 1/e1/0", dv_t, byte_t, gid_t); end
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (16) tick();
    checks++;
    if ({to_t, busy_t} !== 2'b01) begin errors++; $display("FAIL wd_before: to/busy=%b expected 01", {to_t, busy_t}); end
    tick();
    checks++;
    if ({to_t, busy_t, dv_t} !== 3'b100) begin errors++; $display("FAIL wd_pulse: to/busy/dv=%b expected 100", {to_t, busy_t, dv_t}); end
    tick();
    checks++;
    if ({dv_t, byte_t, gid_t, to_t} !== {1'b1, 8'hE2, 2'd1, 1'b0})
      begin errors++; $display("FAIL wd_next: dv=%b byte=%h id=%0d to=%b expected 1/e2/1/0", dv_t, byte_t, gid_t, to_t); end
    tick();
    pulse_done();
`else
    begin
      bit held;
      held = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (to_t || !busy_t || dv_t) held = 1'b0;
      end
      checks++;
      if (held !== 1'b1) begin errors++; $display("FAIL wd_absent: wait_done left or timeout seen, got 0 expected 1"); end
      pulse_done();
      tick();
      checks++;
      if ({dv_t, byte_t, gid_t} !== {1'b1, 8'hE2, 2'd1})
        begin errors++; $display("FAIL wd_absent_next: dv=%b byte=%h id=%0d expected 1/e2/1", dv_t, byte_t, gid_t); end
      tick();
      pulse_done();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fairness();
    test_drop();
    test_strobe_on_grant();
    test_done_ignored();
    test_reset_mid_frame();
    test_gap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
